// File: rtl/hazard_ctrl_pkg.sv
// Shared decode constants, forwarding encodings and the pipeline-entry record
// used by the hazard/forwarding controller.
package hazard_ctrl_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2b;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  localparam logic [1:0] TUSE_0    = 2'd0;
  localparam logic [1:0] TUSE_1    = 2'd1;
  localparam logic [1:0] TUSE_2    = 2'd2;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam logic [1:0] TNEW_0 = 2'd0;
  localparam logic [1:0] TNEW_1 = 2'd1;
  localparam logic [1:0] TNEW_2 = 2'd2;

  localparam logic [1:0] FWD_D_GRF  = 2'd0;
  localparam logic [1:0] FWD_D_E    = 2'd1;
  localparam logic [1:0] FWD_D_M    = 2'd2;
  localparam logic [1:0] FWD_E_PIPE = 2'd0;
  localparam logic [1:0] FWD_E_M    = 2'd1;
  localparam logic [1:0] FWD_E_W    = 2'd2;

  typedef enum logic [3:0] {
    CLS_NOP, CLS_CAL_R, CLS_CAL_I, CLS_LOAD, CLS_STORE, CLS_BEQ,
    CLS_JR, CLS_JAL, CLS_MULT, CLS_DIV, CLS_MF, CLS_MT
  } instr_class_e;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] wa;
    logic [1:0] tnew;
    logic       is_md;
    logic       is_mult;
  } stage_t;

  localparam stage_t STAGE_BUBBLE = '{rs: '0, rt: '0, wa: '0, tnew: TNEW_0,
                                      is_md: 1'b0, is_mult: 1'b0};

  function automatic logic src_used(logic [1:0] tuse);
    return tuse != TUSE_NONE;
  endfunction

  function automatic logic wa_match(logic [4:0] src, stage_t s);
    return (src != '0) && (src == s.wa);
  endfunction

  function automatic logic not_ready(logic [4:0] src, logic [1:0] tuse, stage_t s);
    return src_used(tuse) && wa_match(src, s) && (tuse < s.tnew);
  endfunction

  function automatic logic fwd_ready(logic [4:0] src, stage_t s);
    return wa_match(src, s) && (s.tnew == TNEW_0);
  endfunction

  function automatic stage_t stage_age(stage_t s);
    stage_t r;
    r = s;
    if (r.tnew != TNEW_0) r.tnew = r.tnew - 2'd1;
    return r;
  endfunction

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// D-stage instruction in, stall/forward selects and mult/div busy out.
// master = pipeline side, slave = hazard controller.
interface hazard_ctrl_unit_if;
  logic [31:0] instr_d;
  logic        stall;
  logic [1:0]  fwd_rs_d;
  logic [1:0]  fwd_rt_d;
  logic [1:0]  fwd_rs_e;
  logic [1:0]  fwd_rt_e;
  logic        fwd_rt_m;
  logic        md_busy;

  modport master (
    output instr_d,
    input  stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m, md_busy
  );

  modport slave (
    input  instr_d,
    output stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m, md_busy
  );
endinterface

// File: rtl/hazard_ctrl_unit_instr_classify.sv
// Combinational decode of the D-stage instruction into class, used sources,
// destination and Tuse/Tnew. Unused source fields are reported as $0.
module instr_classify
  import hazard_ctrl_pkg::*;
(
  input  logic [31:0]  instr,
  output instr_class_e cls,
  output logic [4:0]   rs,
  output logic [4:0]   rt,
  output logic [4:0]   wa,
  output logic [1:0]   tuse_rs,
  output logic [1:0]   tuse_rt,
  output logic [1:0]   tnew
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] f_rs;
  logic [4:0] f_rt;
  logic [4:0] f_rd;
  logic       unused_shamt;

  assign op           = instr[31:26];
  assign f_rs         = instr[25:21];
  assign f_rt         = instr[20:16];
  assign f_rd         = instr[15:11];
  assign funct        = instr[5:0];
  assign unused_shamt = ^instr[10:6];

  always_comb begin
    cls     = CLS_NOP;
    tuse_rs = TUSE_NONE;
    tuse_rt = TUSE_NONE;
    wa      = '0;
    tnew    = TNEW_0;
    case (op)
      OP_SPECIAL: begin
        case (funct)
          FN_ADDU, FN_SUBU, FN_ADD, FN_SUB: begin
            cls = CLS_CAL_R; tuse_rs = TUSE_1; tuse_rt = TUSE_1; wa = f_rd; tnew = TNEW_1;
          end
          FN_JR: begin
            cls = CLS_JR; tuse_rs = TUSE_0;
          end
          FN_MULT, FN_MULTU: begin
            cls = CLS_MULT; tuse_rs = TUSE_1; tuse_rt = TUSE_1;
          end
          FN_DIV, FN_DIVU: begin
            cls = CLS_DIV; tuse_rs = TUSE_1; tuse_rt = TUSE_1;
          end
          FN_MFHI, FN_MFLO: begin
            cls = CLS_MF; wa = f_rd; tnew = TNEW_1;
          end
          FN_MTHI, FN_MTLO: begin
            cls = CLS_MT; tuse_rs = TUSE_1;
          end
          default: cls = CLS_NOP;
        endcase
      end
      OP_ORI, OP_LUI: begin
        cls = CLS_CAL_I; tuse_rs = TUSE_1; wa = f_rt; tnew = TNEW_1;
      end
      OP_LW: begin
        cls = CLS_LOAD; tuse_rs = TUSE_1; wa = f_rt; tnew = TNEW_2;
      end
      OP_SW: begin
        cls = CLS_STORE; tuse_rs = TUSE_1; tuse_rt = TUSE_2;
      end
      OP_BEQ: begin
        cls = CLS_BEQ; tuse_rs = TUSE_0; tuse_rt = TUSE_0;
      end
      OP_JAL: begin
        cls = CLS_JAL; wa = 5'd31; tnew = TNEW_0;
      end
      default: cls = CLS_NOP;
    endcase
  end

  assign rs = src_used(tuse_rs) ? f_rs : '0;
  assign rt = src_used(tuse_rt) ? f_rt : '0;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard/forwarding controller for the 5-stage pipeline: tracks D's destination
// through E/M/W, drives stall and forward selects, models the mult/div busy window.
// Build option: FWD_PATHS_EN enables forwarding; undefined = stall-only interlock.
module hazard_ctrl_unit
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10,
  parameter int unsigned CNT_W    = 4
)(
  input  logic               clk,
  input  logic               reset,
  hazard_ctrl_unit_if.slave  hz
);

  instr_class_e cls;
  logic [4:0]   d_rs;
  logic [4:0]   d_rt;
  logic [4:0]   d_wa;
  logic [1:0]   d_tuse_rs;
  logic [1:0]   d_tuse_rt;
  logic [1:0]   d_tnew;

  stage_t       d_entry;
  stage_t       e_q;
  stage_t       m_q;
  stage_t       w_q;
  logic [CNT_W-1:0] md_cnt;
  logic         md_busy;
  logic         d_md_class;
  logic         md_stall;
  logic         hazard_stall;
  logic         stall;
  logic         unused_w;

  instr_classify u_classify (
    .instr   (hz.instr_d),
    .cls     (cls),
    .rs      (d_rs),
    .rt      (d_rt),
    .wa      (d_wa),
    .tuse_rs (d_tuse_rs),
    .tuse_rt (d_tuse_rt),
    .tnew    (d_tnew)
  );

  always_comb begin
    d_entry         = STAGE_BUBBLE;
    d_entry.rs      = d_rs;
    d_entry.rt      = d_rt;
    d_entry.wa      = d_wa;
    d_entry.tnew    = d_tnew;
    d_entry.is_md   = (cls == CLS_MULT) || (cls == CLS_DIV);
    d_entry.is_mult = (cls == CLS_MULT);
  end

  assign md_busy    = (md_cnt != '0);
  assign d_md_class = (cls == CLS_MULT) || (cls == CLS_DIV) ||
                      (cls == CLS_MF)   || (cls == CLS_MT);
  assign md_stall   = d_md_class && (md_busy || e_q.is_md);

  always_comb begin
    hazard_stall = 1'b0;
    hz.fwd_rs_d  = FWD_D_GRF;
    hz.fwd_rt_d  = FWD_D_GRF;
    hz.fwd_rs_e  = FWD_E_PIPE;
    hz.fwd_rt_e  = FWD_E_PIPE;
    hz.fwd_rt_m  = 1'b0;
`ifdef FWD_PATHS_EN
    hazard_stall = not_ready(d_rs, d_tuse_rs, e_q) || not_ready(d_rs, d_tuse_rs, m_q) ||
                   not_ready(d_rt, d_tuse_rt, e_q) || not_ready(d_rt, d_tuse_rt, m_q);
    // Youngest ready producer wins at each consumer point.
    if (fwd_ready(d_rs, e_q))      hz.fwd_rs_d = FWD_D_E;
    else if (fwd_ready(d_rs, m_q)) hz.fwd_rs_d = FWD_D_M;
    if (fwd_ready(d_rt, e_q))      hz.fwd_rt_d = FWD_D_E;
    else if (fwd_ready(d_rt, m_q)) hz.fwd_rt_d = FWD_D_M;
    if (fwd_ready(e_q.rs, m_q))      hz.fwd_rs_e = FWD_E_M;
    else if (fwd_ready(e_q.rs, w_q)) hz.fwd_rs_e = FWD_E_W;
    if (fwd_ready(e_q.rt, m_q))      hz.fwd_rt_e = FWD_E_M;
    else if (fwd_ready(e_q.rt, w_q)) hz.fwd_rt_e = FWD_E_W;
    hz.fwd_rt_m = fwd_ready(m_q.rt, w_q);
`else
    hazard_stall = (src_used(d_tuse_rs) &&
                    (wa_match(d_rs, e_q) || wa_match(d_rs, m_q) || wa_match(d_rs, w_q))) ||
                   (src_used(d_tuse_rt) &&
                    (wa_match(d_rt, e_q) || wa_match(d_rt, m_q) || wa_match(d_rt, w_q)));
`endif
  end

  assign stall      = hazard_stall || md_stall;
  assign hz.stall   = stall;
  assign hz.md_busy = md_busy;
  assign unused_w   = ^{w_q.rs, w_q.rt, w_q.tnew, w_q.is_md, w_q.is_mult};

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q <= STAGE_BUBBLE;
      m_q <= STAGE_BUBBLE;
      w_q <= STAGE_BUBBLE;
    end else begin
      w_q <= stage_age(m_q);
      m_q <= stage_age(e_q);
      e_q <= stall ? STAGE_BUBBLE : d_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      md_cnt <= '0;
    else if (e_q.is_md)
      md_cnt <= e_q.is_mult ? CNT_W'(MULT_CYC) : CNT_W'(DIV_CYC);
    else if (md_cnt != '0)
      md_cnt <= md_cnt - 1'b1;
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed self-checking bench for hazard_ctrl_unit; expectations follow the
// FWD_PATHS_EN build option.
module tb_hazard_ctrl_unit;

`ifdef FWD_PATHS_EN
  localparam int unsigned S_LW = 1, S_SW = 0, S_BEQ = 1, S_JR = 0, S_RR = 0;
  localparam logic [1:0] FD_E = 2'd1, FD_M = 2'd2, FE_M = 2'd1, FE_W = 2'd2;
  localparam logic       FM_W = 1'b1;
`else
  localparam int unsigned S_LW = 3, S_SW = 3, S_BEQ = 3, S_JR = 3, S_RR = 3;
  localparam logic [1:0] FD_E = 2'd0, FD_M = 2'd0, FE_M = 2'd0, FE_W = 2'd0;
  localparam logic       FM_W = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int unsigned checks = 0;
  int unsigned errors = 0;

  hazard_ctrl_unit_if hz ();

  hazard_ctrl_unit #(.MULT_CYC(5), .DIV_CYC(10), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                        logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                        logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    hz.instr_d = 32'h0;
    repeat (3) tick();
  endtask

  task automatic chk1(input string tag, input string sig, input logic [1:0] obs,
                      input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed %0d expected %0d", tag, sig, obs, exp);
    end
  endtask

  task automatic chk(input string tag, input logic st, input logic [1:0] rsd,
                     input logic [1:0] rtd, input logic [1:0] rse, input logic [1:0] rte,
                     input logic rtm, input logic busy);
    @(negedge clk);
    chk1(tag, "stall",    {1'b0, hz.stall},    {1'b0, st});
    chk1(tag, "fwd_rs_d", hz.fwd_rs_d,         rsd);
    chk1(tag, "fwd_rt_d", hz.fwd_rt_d,         rtd);
    chk1(tag, "fwd_rs_e", hz.fwd_rs_e,         rse);
    chk1(tag, "fwd_rt_e", hz.fwd_rt_e,         rte);
    chk1(tag, "fwd_rt_m", {1'b0, hz.fwd_rt_m}, {1'b0, rtm});
    chk1(tag, "md_busy",  {1'b0, hz.md_busy},  {1'b0, busy});
  endtask

  initial begin
    hz.instr_d = 32'h0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset", 0, 0, 0, 0, 0, 0, 0);
    tick();

    // lw $1,0($0) ; addu $2,$1,$3
    hz.instr_d = itype(6'h23, 5'd0, 5'd1, 16'd0);
    chk("lw_issue", 0, 0, 0, 0, 0, 0, 0); tick();
    hz.instr_d = rtype(5'd1, 5'd3, 5'd2, 6'h21);
    for (int unsigned i = 0; i < S_LW; i++) begin
      chk("lw_use_stall", 1, 0, 0, 0, 0, 0, 0); tick();
    end
    chk("lw_use_go", 0, 0, 0, 0, 0, 0, 0); tick();
    hz.instr_d = 32'h0;
    chk("lw_fwd_e", 0, 0, 0, FE_W, 0, 0, 0); tick();
    flush();

    // ori $6,$0,1 ; sw $6,0($0)
    hz.instr_d = itype(6'h0d, 5'd0, 5'd6, 16'd1);
    chk("ori6_issue", 0, 0, 0, 0, 0, 0, 0); tick();
    hz.instr_d = itype(6'h2b, 5'd0, 5'd6, 16'd0);
    for (int unsigned i = 0; i < S_SW; i++) begin
      chk("sw_stall", 1, 0, 0, 0, 0, 0, 0); tick();
    end
    chk("sw_go", 0, 0, 0, 0, 0, 0, 0); tick();
    hz.instr_d = 32'h0;
    chk("sw_fwd_e", 0, 0, 0, 0, FE_M, 0, 0); tick();
    chk("sw_fwd_m", 0, 0, 0, 0, 0, FM_W, 0); tick();
    flush();

    // ori $5,$0,7 ; beq $5,$0
    hz.instr_d = itype(6'h0d, 5'd0, 5'd5, 16'd7);
    chk("ori5_issue", 0, 0, 0, 0, 0, 0, 0); tick();
    hz.instr_d = itype(6'h04, 5'd5, 5'd0, 16'd0);
    for (int unsigned i = 0; i < S_BEQ; i++) begin
      chk("beq_stall", 1, 0, 0, 0, 0, 0, 0); tick();
    end
    chk("beq_fwd_d", 0, FD_M, 0, 0, 0, 0, 0); tick();
    hz.instr_d = 32'h0;
    chk("beq_fwd_e", 0, 0, 0, FE_W, 0, 0, 0); tick();
    flush();

    // jal ; jr $31
    hz.instr_d = {6'h03, 26'h10};
    chk("jal_issue", 0, 0, 0, 0, 0, 0, 0); tick();
    hz.instr_d = rtype(5'd31, 5'd0, 5'd0, 6'h08);
    for (int unsigned i = 0; i < S_JR; i++) begin
      chk("jr_stall", 1, 0, 0, 0, 0, 0, 0); tick();
    end
    chk("jr_fwd_d", 0, FD_E, 0, 0, 0, 0, 0); tick();
    hz.instr_d = 32'h0;
    chk("jr_fwd_e", 0, 0, 0, FE_M, 0, 0, 0); tick();
    flush();

    // mult $1,$2 ; mflo $3
    hz.instr_d = rtype(5'd1, 5'd2, 5'd0, 6'h18);
    chk("mult_issue", 0, 0, 0, 0, 0, 0, 0); tick();
    hz.instr_d = rtype(5'd0, 5'd0, 5'd3, 6'h12);
    chk("mflo_e_md", 1, 0, 0, 0, 0, 0, 0); tick();
    for (int unsigned i = 0; i < 5; i++) begin
      chk("mflo_busy", 1, 0, 0, 0, 0, 0, 1); tick();
    end
    chk("mflo_go", 0, 0, 0, 0, 0, 0, 0); tick();
    flush();

    // div $1,$2 ; mfhi $4
    hz.instr_d = rtype(5'd1, 5'd2, 5'd0, 6'h1a);
    chk("div_issue", 0, 0, 0, 0, 0, 0, 0); tick();
    hz.instr_d = rtype(5'd0, 5'd0, 5'd4, 6'h10);
    chk("mfhi_e_md", 1, 0, 0, 0, 0, 0, 0); tick();
    for (int unsigned i = 0; i < 10; i++) begin
      chk("mfhi_busy", 1, 0, 0, 0, 0, 0, 1); tick();
    end
    chk("mfhi_go", 0, 0, 0, 0, 0, 0, 0); tick();
    flush();

    // reset while the multiplier is busy
    hz.instr_d = rtype(5'd1, 5'd2, 5'd0, 6'h19);
    chk("multu_issue", 0, 0, 0, 0, 0, 0, 0); tick();
    hz.instr_d = 32'h0;
    chk("multu_in_e", 0, 0, 0, 0, 0, 0, 0); tick();
    chk("multu_busy", 0, 0, 0, 0, 0, 0, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("reset_abort", 0, 0, 0, 0, 0, 0, 0); tick();

    // addu $0,$1,$2 ; addu $4,$0,$0
    hz.instr_d = rtype(5'd1, 5'd2, 5'd0, 6'h21);
    chk("zero_dest", 0, 0, 0, 0, 0, 0, 0); tick();
    hz.instr_d = rtype(5'd0, 5'd0, 5'd4, 6'h21);
    chk("zero_src", 0, 0, 0, 0, 0, 0, 0); tick();
    hz.instr_d = 32'h0;
    chk("zero_src_e", 0, 0, 0, 0, 0, 0, 0); tick();
    flush();

    // addu $1,$0,$0 ; addu $2,$1,$1
    hz.instr_d = rtype(5'd0, 5'd0, 5'd1, 6'h21);
    chk("rr_issue", 0, 0, 0, 0, 0, 0, 0); tick();
    hz.instr_d = rtype(5'd1, 5'd1, 5'd2, 6'h21);
    for (int unsigned i = 0; i < S_RR; i++) begin
      chk("rr_stall", 1, 0, 0, 0, 0, 0, 0); tick();
    end
    chk("rr_go", 0, 0, 0, 0, 0, 0, 0); tick();
    hz.instr_d = 32'h0;
    chk("rr_fwd_e", 0, 0, 0, FE_M, FE_M, 0, 0); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
